vend_dispense_ctrl: RTL

//  Sequences product release and change payout once the coin-acceptance FSM has collected enough credit.

---
 rtl/vend_pkg.sv | 38 +++
 rtl/vend_timeout_timer.sv | 27 ++
 rtl/vend_dispense_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: FSM state codes, hopper select codes,
// coin values in nickels, fault codes. Also used by the coin-acceptance FSM.
package vend_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CHECK  = 3'd1;
  localparam state_t ST_VEND   = 3'd2;
  localparam state_t ST_CHANGE = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
  localparam state_t ST_FAULT  = 3'd5;

  localparam logic [1:0] HOP_NICKEL  = 2'b00;
  localparam logic [1:0] HOP_DIME    = 2'b01;
  localparam logic [1:0] HOP_QUARTER = 2'b10;

  localparam logic [2:0] VAL_NICKEL  = 3'd1;
  localparam logic [2:0] VAL_DIME    = 3'd2;
  localparam logic [2:0] VAL_QUARTER = 3'd5;

  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_MOTOR  = 2'b01;
  localparam logic [1:0] FAULT_HOPPER = 2'b10;
  localparam logic [1:0] FAULT_SHORT  = 2'b11;

  function automatic logic [2:0] coin_val(input logic [1:0] sel);
    logic [2:0] v;
    case (sel)
      HOP_NICKEL:  v = VAL_NICKEL;
      HOP_DIME:    v = VAL_DIME;
      HOP_QUARTER: v = VAL_QUARTER;
      default:     v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Handshake watchdog: counts while en, zeroed by clear/reset.
// Ports: clk, reset, clear, en, limit (runtime, <= LIMIT), expired (cnt >= limit).
module vend_timeout_timer #(
  parameter int LIMIT = 1000,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  assign expired = (cnt >= limit);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vend sequencer: checks credit, runs product motor, pays change greedily.
// Ports: start/credit/price in, ready/reject out; motor_req/motor_done;
// hop_req/hop_sel/hop_ack + empty flags; done, fault/fault_code, clr_fault.
// Build option: VEND_QUARTER_CHANGE_EN adds quarters to the change order.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 6,
  parameter int MOTOR_TO = 1000,
  parameter int HOP_TO   = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  input  logic [CREDIT_W-1:0] price,
  output logic                ready,
  output logic                reject,
  output logic                motor_req,
  input  logic                motor_done,
  output logic                hop_req,
  output logic [1:0]          hop_sel,
  input  logic                hop_ack,
  input  logic                nik_empty,
  input  logic                dim_empty,
  input  logic                qtr_empty,
  output logic                done,
  output logic                fault,
  output logic [1:0]          fault_code,
  input  logic                clr_fault
);

  localparam int TMAX = (MOTOR_TO > HOP_TO) ? MOTOR_TO : HOP_TO;
  localparam int TW   = $clog2(TMAX + 1);

  state_t              state;
  logic [CREDIT_W-1:0] cr_q;
  logic [CREDIT_W-1:0] pr_q;
  logic [CREDIT_W-1:0] rem_q;
  logic                short_cr;
  logic                tmr_run;
  logic                expired;
  logic [TW-1:0]       tmr_lim;
  logic                use_qtr;
  logic                pick_ok;
  logic [1:0]          pick_sel;

  assign short_cr  = (cr_q < pr_q);
  assign ready     = (state == ST_IDLE);
  assign reject    = (state == ST_CHECK) && short_cr;
  assign motor_req = (state == ST_VEND);
  assign done      = (state == ST_DONE);
  assign fault     = (state == ST_FAULT);

  // One watchdog serves both waits; it restarts whenever no wait is open,
  // so each coin gets a fresh window.
  assign tmr_run = (state == ST_VEND) ||
                   ((state == ST_CHANGE) && hop_req);
  assign tmr_lim = (state == ST_VEND) ? TW'(MOTOR_TO) : TW'(HOP_TO);

  vend_timeout_timer #(
    .LIMIT (TMAX),
    .W     (TW)
  ) u_tmr (
    .clk     (clk),
    .reset   (reset),
    .clear   (!tmr_run),
    .en      (tmr_run),
    .limit   (tmr_lim),
    .expired (expired)
  );

`ifdef VEND_QUARTER_CHANGE_EN
  assign use_qtr = (rem_q >= CREDIT_W'(VAL_QUARTER)) && !qtr_empty;
`else
  logic unused_qtr;
  assign unused_qtr = qtr_empty;
  assign use_qtr    = 1'b0;
`endif

  // Greedy pick; empty flags only matter here, i.e. while hop_req is low.
  always_comb begin
    pick_ok  = 1'b1;
    pick_sel = HOP_NICKEL;
    if (use_qtr) begin
      pick_sel = HOP_QUARTER;
    end else if ((rem_q >= CREDIT_W'(VAL_DIME)) && !dim_empty) begin
      pick_sel = HOP_DIME;
    end else if ((rem_q != '0) && !nik_empty) begin
      pick_sel = HOP_NICKEL;
    end else begin
      pick_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cr_q       <= '0;
      pr_q       <= '0;
      rem_q      <= '0;
      hop_req    <= 1'b0;
      hop_sel    <= HOP_NICKEL;
      fault_code <= FAULT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cr_q  <= credit;
            pr_q  <= price;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (short_cr) begin
            state <= ST_IDLE;
          end else begin
            rem_q <= cr_q - pr_q;
            state <= ST_VEND;
          end
        end
        ST_VEND: begin
          if (motor_done) begin
            state <= ST_CHANGE;
          end else if (expired) begin
            fault_code <= FAULT_MOTOR;
            state      <= ST_FAULT;
          end
        end
        ST_CHANGE: begin
          if (hop_req) begin
            if (hop_ack) begin
              rem_q   <= rem_q - CREDIT_W'(coin_val(hop_sel));
              hop_req <= 1'b0;
            end else if (expired) begin
              hop_req    <= 1'b0;
              fault_code <= FAULT_HOPPER;
              state      <= ST_FAULT;
            end
          end else if (rem_q == '0) begin
            state <= ST_DONE;
          end else if (pick_ok) begin
            hop_sel <= pick_sel;
            hop_req <= 1'b1;
          end else begin
            fault_code <= FAULT_SHORT;
            state      <= ST_FAULT;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_FAULT: begin
          if (clr_fault) begin
            fault_code <= FAULT_NONE;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
